// File: rtl/wam_dsp.sv
// Drives the three BCD score digits onto a 4-digit common-anode 7-segment display.
// Each scan frame takes one snapshot of the score, and a level-up blinks the display.
//
// state | meaning
// NORM  | digits scan normally
// FLASH | digits scan, but all anodes turn off on odd BLINK-frame groups
module wam_dsp #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK        = 8,
    parameter int unsigned FLASH_FRAMES = 64
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [11:0] num,
    input  logic        lvl_up,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    typedef enum logic {NORM, FLASH} state_t;

    state_t        state, state_nx;
    logic [FW-1:0] fcnt, fcnt_nx;
    logic [CW-1:0] cnt;
    logic [1:0]    sel;
    logic [11:0]   shadow;
    logic          tick, frame_end;
    logic [3:0]    digit;
    logic          blank, dark;
    logic [6:0]    seg_d;
    logic [3:0]    an_d;

    assign tick      = (cnt == CW'(SCAN_DIV - 1));
    assign frame_end = tick && (sel == 2'd2);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt    <= '0;
            sel    <= 2'd0;
            shadow <= 12'h000;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                sel <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
            if (frame_end)
                shadow <= num;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= NORM;
            fcnt  <= '0;
        end else begin
            state <= state_nx;
            fcnt  <= fcnt_nx;
        end
    end

    // A level-up pulse always restarts the flash, even on its final frame_end.
    always_comb begin
        state_nx = state;
        fcnt_nx  = fcnt;
        if (lvl_up) begin
            state_nx = FLASH;
            fcnt_nx  = '0;
        end else if (state == FLASH && frame_end) begin
            if (fcnt == FW'(FLASH_FRAMES - 1)) begin
                state_nx = NORM;
                fcnt_nx  = '0;
            end else begin
                fcnt_nx = fcnt + 1'b1;
            end
        end
    end

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    always_comb begin
        digit = shadow[3:0];
        blank = 1'b0;
        an_d  = 4'hE;
        case (sel)
            2'd1: begin
                digit = shadow[7:4];
                blank = (shadow[11:8] == 4'd0) && (shadow[7:4] == 4'd0);
                an_d  = 4'hD;
            end
            2'd2: begin
                digit = shadow[11:8];
                blank = (shadow[11:8] == 4'd0);
                an_d  = 4'hB;
            end
            default: ;
        endcase
        dark  = (state == FLASH) && (((32'(fcnt) / BLINK) % 32'd2) == 32'd1);
        seg_d = blank ? 7'h7F : decode(digit);
        if (dark)
            an_d = 4'hF;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            seg <= 7'h7F;
            an  <= 4'hF;
            dp  <= 1'b1;
        end else begin
            seg <= seg_d;
            an  <= an_d;
            dp  <= 1'b1;
        end
    end

endmodule
